// File: rtl/os_result_drain_if.sv
// Byte-wide valid/ready stream carrying drained OS results toward the output pins.
// The master drives data/valid/last; the slave (pin-side sink) returns ready.
interface os_result_drain_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/os_result_drain.sv
// Captures OS-phase PE results into a slot buffer and streams them out MSB byte first.
// Optional OS_DRAIN_SAT8_EN: saturate each result to signed 8 bits, one byte per slot.
module os_result_drain #(
  parameter int NUM_OUT = 9,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [3:0]        OSOutSel,
  input  logic [DATA_W-1:0] psum,
  input  logic              end_OS,
  os_result_drain_if.master byte_if,
  output logic              overflow,
  output logic              busy
);

`ifdef OS_DRAIN_SAT8_EN
  localparam int BYTES = 1;
`else
  localparam int BYTES = DATA_W / 8;
`endif
  localparam int SLOT_W = 8 * BYTES;

  localparam logic [0:0] DRAIN_WAIT = 1'b0;
  localparam logic [0:0] DRAIN_SEND = 1'b1;

  logic [SLOT_W-1:0]  buf_q [NUM_OUT];
  logic [NUM_OUT-1:0] vld_q, vld_keep, vld_d;
  logic [3:0]         rd_ptr, next_ptr, wr_idx;
  logic [1:0]         b_idx;
  logic [0:0]         state;
  logic               sel_hit, cap_ok, cap_drop, xfer, word_done;
  logic [SLOT_W-1:0]  cap_word, cur_word;

  assign sel_hit   = (OSOutSel != 4'd0) && (OSOutSel <= 4'(NUM_OUT));
  assign wr_idx    = OSOutSel - 4'd1;
  // Occupancy is judged on the pre-edge vld, so a slot finishing its drain this cycle still drops.
  assign cap_ok    = sel_hit && !vld_q[wr_idx];
  assign cap_drop  = sel_hit &&  vld_q[wr_idx];
  assign xfer      = (state == DRAIN_SEND) && byte_if.out_ready;
  assign word_done = xfer && (b_idx == 2'(BYTES - 1));
  assign next_ptr  = (rd_ptr == 4'(NUM_OUT - 1)) ? 4'd0 : rd_ptr + 4'd1;

`ifdef OS_DRAIN_SAT8_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(127);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-128);

  always_comb begin
    if ($signed(psum) > SAT_MAX)      cap_word = 8'h7F;
    else if ($signed(psum) < SAT_MIN) cap_word = 8'h80;
    else                              cap_word = psum[7:0];
  end
`else
  assign cap_word = psum;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    vld_keep = vld_q;
    if (word_done) vld_keep[rd_ptr] = 1'b0;
    vld_d = vld_keep;
    if (cap_ok) vld_d[wr_idx] = 1'b1;
  end

  // NOTE: the result buffer has no reset; vld_q alone says which entries mean anything.
  always_ff @(posedge clk) begin
    if (cap_ok) buf_q[wr_idx] <= cap_word;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= DRAIN_WAIT;
      rd_ptr   <= 4'd0;
      b_idx    <= 2'd0;
      vld_q    <= '0;
      overflow <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (cap_drop)    overflow <= 1'b1;
      else if (end_OS) overflow <= 1'b0;

      case (state)
        DRAIN_WAIT: if (vld_q[rd_ptr]) state <= DRAIN_SEND;
        default: begin
          if (word_done) begin
            b_idx  <= 2'd0;
            rd_ptr <= next_ptr;
            // Back-to-back slots stream without a bubble when the next one is already waiting.
            if (!vld_keep[next_ptr]) state <= DRAIN_WAIT;
          end else if (xfer) begin
            b_idx <= b_idx + 2'd1;
          end
        end
      endcase
    end
  end

  assign cur_word = buf_q[rd_ptr];

  always_comb begin
    byte_if.out_data = 8'h00;
    if (state == DRAIN_SEND) begin
      for (int i = 0; i < BYTES; i++) begin
        if (b_idx == 2'(BYTES - 1 - i)) byte_if.out_data = cur_word[8*i +: 8];
      end
    end
  end

  assign byte_if.out_valid = (state == DRAIN_SEND);
  assign byte_if.out_last  = (state == DRAIN_SEND) && (rd_ptr == 4'(NUM_OUT - 1))
                             && (b_idx == 2'(BYTES - 1));
  assign busy = (|vld_q) || (state == DRAIN_SEND);

endmodule

// File: tb/tb_os_result_drain.sv
// Self-checking bench for os_result_drain: directed scenarios plus randomized frames
// checked against a slot-order byte-stream model.
module tb_os_result_drain;
  localparam int NUM_OUT = 9;
  localparam int DATA_W  = 16;
`ifdef OS_DRAIN_SAT8_EN
  localparam int BPS = 1;
`else
  localparam int BPS = 2;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  OSOutSel = 4'd0;
  logic [15:0] psum = 16'h0;
  logic        end_OS = 1'b0;
  logic        overflow, busy;

  os_result_drain_if bif();

  os_result_drain #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .RST      (RST),
    .OSOutSel (OSOutSel),
    .psum     (psum),
    .end_OS   (end_OS),
    .byte_if  (bif),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         mon_en  = 1'b0;
  logic [7:0] mon_data[$];
  bit         mon_last[$];
  int         mon_cyc[$];
  logic [7:0] exp_data[$];

  // Records every accepted byte; sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
      mon_data.push_back(bif.out_data);
      mon_last.push_back(bif.out_last === 1'b1);
      mon_cyc.push_back(cyc);
    end
  end

  // Model: the stored value of a result, then its bytes most significant first.
  function automatic logic [7:0] model_byte(input logic [15:0] w, input int b);
`ifdef OS_DRAIN_SAT8_EN
    int v;
    v = int'($signed(w));
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return w[7:0];
`else
    logic [15:0] s;
    s = w >> (8 * b);
    return s[7:0];
`endif
  endfunction

  function automatic void model_slot(input logic [15:0] w);
    for (int b = BPS - 1; b >= 0; b--) exp_data.push_back(model_byte(w, b));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_last.delete();
    mon_cyc.delete();
  endtask

  task automatic apply_reset();
    RST = 1'b1; OSOutSel = 4'd0; end_OS = 1'b0; bif.out_ready = 1'b0;
    step();
    RST = 1'b0;
    clear_mon();
    exp_data.delete();
    mon_en = 1'b1;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    for (int i = 0; i < limit && mon_data.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; OSOutSel = 4'd0; end_OS = 1'b0; bif.out_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bif.out_valid); end
    n_tests++; if (bif.out_last  !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bif.out_last); end
    n_tests++; if (busy          !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (overflow      !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if (bif.out_data  !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bif.out_data); end
    step();
    RST = 1'b0;
  endtask

  task automatic test_frame();
    apply_reset();
    bif.out_ready = 1'b1;
    for (int k = 1; k <= NUM_OUT; k++) begin
      step();
      OSOutSel = 4'(k);
      psum = 16'h0101 * 16'(k);
      model_slot(psum);
    end
    step();
    OSOutSel = 4'd0;
    wait_bytes(exp_data.size(), 100);
    n_tests++;
    if (mon_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL frame_count: got %0d want %0d", mon_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
      n_tests++;
      if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL frame_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
      n_tests++;
      if (mon_last[i] != (i == exp_data.size() - 1)) begin n_fail++; $display("FAIL frame_last[%0d]: got %b want %b", i, mon_last[i], i == exp_data.size() - 1); end
      if (i > 0) begin
        n_tests++;
        if (mon_cyc[i] - mon_cyc[i-1] != 1) begin n_fail++; $display("FAIL frame_gap[%0d]: got %0d cycles want 1", i, mon_cyc[i] - mon_cyc[i-1]); end
      end
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_last: got %b want 1", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b want 0", busy); end
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL frame_valid_after: got %b want 0", bif.out_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step();
    OSOutSel = 4'd1; psum = 16'hABCD; model_slot(psum);
    step();
    OSOutSel = 4'd0;
    @(negedge clk);
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_latency0: got %b want 0", bif.out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bif.out_valid); end
      n_tests++; if (bif.out_data !== exp_data[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, bif.out_data, exp_data[0]); end
    end
    step();
    bif.out_ready = 1'b1;
    wait_bytes(BPS, 20);
    repeat (4) @(negedge clk);
    n_tests++; if (mon_data.size() != BPS) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", mon_data.size(), BPS); end
    for (int i = 0; i < BPS && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    bif.out_ready = 1'b1;
    step();
    OSOutSel = 4'd3; psum = 16'h0033;
    step();
    OSOutSel = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait_valid[%0d]: got %b want 0", i, bif.out_valid); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ooo_wait_busy[%0d]: got %b want 1", i, busy); end
    end
    step(); OSOutSel = 4'd1; psum = 16'h0011;
    step(); OSOutSel = 4'd2; psum = 16'h0022;
    step(); OSOutSel = 4'd0;
    model_slot(16'h0011); model_slot(16'h0022); model_slot(16'h0033);
    wait_bytes(exp_data.size(), 50);
    n_tests++; if (mon_data.size() != exp_data.size()) begin n_fail++; $display("FAIL ooo_count: got %0d want %0d", mon_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL ooo_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    step(); OSOutSel = 4'd1; psum = 16'h1111; model_slot(psum);
    step(); OSOutSel = 4'd1; psum = 16'h2222;
    step(); OSOutSel = 4'd0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    step(); end_OS = 1'b1;
    step(); end_OS = 1'b0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    step(); end_OS = 1'b1; OSOutSel = 4'd1; psum = 16'h3333;
    step(); end_OS = 1'b0; OSOutSel = 4'd0;
    @(negedge clk);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    step(); OSOutSel = 4'd12;
    step(); OSOutSel = 4'd0;
    bif.out_ready = 1'b1;
    wait_bytes(BPS, 20);
    repeat (4) @(negedge clk);
    n_tests++; if (mon_data.size() != BPS) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", mon_data.size(), BPS); end
    for (int i = 0; i < BPS && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    bif.out_ready = 1'b1;
    for (int k = 1; k <= NUM_OUT; k++) begin
      step();
      OSOutSel = 4'(k);
      psum = 16'($urandom);
      model_slot(psum);
    end
    step(); OSOutSel = 4'(NUM_OUT); psum = 16'hDEAD;
    step(); OSOutSel = 4'd0;
    wait_bytes(7, 100);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_ovf_pre: got %b want 1", overflow); end
    for (int i = 0; i < 7 && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL mid_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
    end
    RST = 1'b1;
    #1;
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bif.out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
    step();
    RST = 1'b0;
    clear_mon();
    exp_data.delete();
    step(); OSOutSel = 4'd1; psum = 16'hBEEF; model_slot(psum);
    step(); OSOutSel = 4'd0;
    wait_bytes(BPS, 20);
    repeat (3) @(negedge clk);
    n_tests++; if (mon_data.size() != BPS) begin n_fail++; $display("FAIL mid_new_count: got %0d want %0d", mon_data.size(), BPS); end
    for (int i = 0; i < BPS && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL mid_new_byte[%0d]: got %h want %h", i, mon_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_random();
    int          perm [NUM_OUT];
    logic [15:0] vals [NUM_OUT];
    int          idx, gap, j, t;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      exp_data.delete();
      for (int s = 0; s < NUM_OUT; s++) begin
        perm[s] = s;
        vals[s] = 16'($urandom);
      end
      for (int s = NUM_OUT - 1; s > 0; s--) begin
        j = int'($urandom_range(0, s));
        t = perm[s]; perm[s] = perm[j]; perm[j] = t;
      end
      for (int s = 0; s < NUM_OUT; s++) model_slot(vals[s]);
      idx = 0;
      gap = int'($urandom_range(0, 3));
      for (int c = 0; c < 400 && (idx < NUM_OUT || mon_data.size() < exp_data.size()); c++) begin
        step();
        bif.out_ready = ($urandom_range(0, 3) != 0);
        if (idx < NUM_OUT && gap == 0) begin
          OSOutSel = 4'(perm[idx] + 1);
          psum = vals[perm[idx]];
          idx++;
          gap = int'($urandom_range(0, 3));
        end else begin
          OSOutSel = 4'd0;
          if (gap > 0) gap--;
        end
      end
      step();
      OSOutSel = 4'd0;
      bif.out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (mon_data.size() != exp_data.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", f, mon_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
        n_tests++; if (mon_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL rnd%0d_byte[%0d]: got %h want %h", f, i, mon_data[i], exp_data[i]); end
        n_tests++; if (mon_last[i] != (i == exp_data.size() - 1)) begin n_fail++; $display("FAIL rnd%0d_last[%0d]: got %b", f, i, mon_last[i]); end
      end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_overflow: got %b want 0", f, overflow); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b want 0", f, busy); end
    end
  endtask

`ifdef OS_DRAIN_SAT8_EN
  task automatic test_sat8();
    logic [15:0] ins [3];
    logic [7:0]  want [3];
    ins[0] = 16'h0200; ins[1] = 16'hFF00; ins[2] = 16'h0045;
    want[0] = 8'h7F;   want[1] = 8'h80;   want[2] = 8'h45;
    apply_reset();
    bif.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      OSOutSel = 4'(k + 1);
      psum = ins[k];
    end
    step();
    OSOutSel = 4'd0;
    wait_bytes(3, 30);
    repeat (3) @(negedge clk);
    n_tests++; if (mon_data.size() != 3) begin n_fail++; $display("FAIL sat_count: got %0d want 3", mon_data.size()); end
    for (int i = 0; i < 3 && i < mon_data.size(); i++) begin
      n_tests++; if (mon_data[i] !== want[i]) begin n_fail++; $display("FAIL sat_byte[%0d]: got %h want %h", i, mon_data[i], want[i]); end
      n_tests++; if (mon_last[i]) begin n_fail++; $display("FAIL sat_last[%0d]: got 1 want 0", i); end
    end
  endtask
`endif

  initial begin
    bif.out_ready = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_out_of_order();
    test_overflow();
    test_reset_mid_drain();
    test_random();
`ifdef OS_DRAIN_SAT8_EN
    test_sat8();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/os_result_drain.md
Name: os_result_drain

Overview:
- Downstream of the top-level controller's output-stationary (OS) phase.
- Captures the accumulated PE results presented one per cycle while `OSOutSel` steps 1..NUM_OUT, into a frame buffer.
- Streams the buffer out MSB-byte-first over an 8-bit valid/ready byte interface toward the chip output pins.
- Tracks frame boundaries and flags results that arrive before their slot has been drained.

Parameters:
- NUM_OUT, 9, number of result slots per frame (`OSOutSel` values 1..NUM_OUT); range 1..15.
- DATA_W, 16, width of one PE result; multiple of 8 in 8..32; BYTES = DATA_W/8.

Ports:
- clk  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- OSOutSel  input  4  slot select from controller; 0 = no capture; 1..NUM_OUT = `psum` belongs to slot OSOutSel-1.
- psum  input  DATA_W  selected PE result, sampled when OSOutSel is in range.
- end_OS  input  1  controller pulse at start of a new job.
- out_data  output  8  current byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  sink accepts the byte; transfer = out_valid & out_ready.
- out_last  output  1  qualifies the final byte of a frame.
- overflow  output  1  sticky drop flag.
- busy  output  1  any slot valid.

Behaviour:
- Storage:
  - buf[NUM_OUT] of DATA_W bits, plus per-slot `vld` bits.
  - Read pointer `rdPtr` (0..NUM_OUT-1) and byte index `bIdx` (0..BYTES-1).
- Reset (RST=1, asynchronous):
  - vld=0, rdPtr=0, bIdx=0, overflow=0.
  - Outputs: out_valid=0, out_last=0, busy=0, out_data=0.
- Capture:
  - On a clock edge with 1<=OSOutSel<=NUM_OUT and vld[OSOutSel-1]=0: buf[OSOutSel-1]<=psum and vld set.
  - If vld[OSOutSel-1]=1 (using the pre-edge value): the write is dropped, the slot is unchanged, and overflow<=1.
  - This holds even when that slot's last byte is accepted in the same cycle; the slot clears and the new value is lost.
  - OSOutSel=0 or >NUM_OUT: ignored, no flag.
- Drain state machine: states DRAIN_WAIT and DRAIN_SEND.
  - DRAIN_WAIT: out_valid=0. Go to DRAIN_SEND on the edge after vld[rdPtr]=1.
  - DRAIN_SEND: out_valid=1.
    - out_data = byte (BYTES-1-bIdx) of buf[rdPtr], so the MSB byte goes first.
    - out_data is held stable while out_valid=1 and out_ready=0.
    - On each transfer, bIdx increments.
  - On transfer of byte BYTES-1:
    - bIdx<=0 and vld[rdPtr]<=0.
    - rdPtr increments, wrapping NUM_OUT-1 -> 0.
    - Go to DRAIN_WAIT unless vld[next rdPtr] is already 1, in which case stay in DRAIN_SEND with no bubble.
- out_last = out_valid & (rdPtr==NUM_OUT-1) & (bIdx==BYTES-1).
- Latency: a capture edge into slot rdPtr while idle gives out_valid=1 one cycle later. Byte throughput is 1 per cycle with out_ready held high.
- Slots drain strictly in order 0..NUM_OUT-1, regardless of capture order. A later slot captured first waits.
- end_OS=1:
  - Clears overflow.
  - Does not touch vld, buf or the drain pointers; in-flight data completes.
  - If end_OS and a new overflow condition occur in the same cycle, set wins.
- busy = |vld | (state==DRAIN_SEND).
- Asynchronous RST mid-frame discards all buffered data immediately.
- All outputs are registered or are decoded from registered state only. There are no combinational paths from out_ready or OSOutSel to any output.

Optional Feature:
- Macro: OS_DRAIN_SAT8_EN.
- Defined:
  - Each captured psum is treated as signed and saturated to signed 8 bits before storage: >127 -> 0x7F, <-128 -> 0x80.
  - Effective BYTES=1, so one byte per slot, and out_last asserts on the slot NUM_OUT-1 byte.
- Undefined: full DATA_W words are streamed as BYTES bytes, as described above.

Test Plan:
- Frame streaming: reset, then OSOutSel=1..9 on consecutive cycles with psum=0x0101*k for k=1..9 (k=slot number), out_ready=1 → 18 bytes 01,01,02,02,…,09,09, no gaps after the first; out_last only with the final 09; busy falls the cycle after.
- Backpressure: one slot, psum=0xABCD, out_ready low for 5 cycles → out_data=AB held stable with out_valid=1; after ready, AB then CD transferred exactly once each.
- Out-of-order capture: slot 3 written first (OSOutSel=3, 0x0033), then slot 1, then slot 2 → bytes emitted for slot 1, then 2, then 3; out_valid stays 0 until slot 1 is captured.
- Overflow: out_ready=0, capture slot 1=0x1111, then OSOutSel=1 with 0x2222 → overflow=1 and stream later yields 11,11. An end_OS pulse then clears overflow; a simultaneous end_OS plus drop leaves overflow=1.
- Reset mid-drain: assert RST after 7 of 18 bytes → out_valid, busy and overflow go 0 immediately. A new frame afterwards starts from slot 0 with correct data.
- With OS_DRAIN_SAT8_EN defined: psum=0x0200, 0xFF00, 0x0045 in slots 1..3 → bytes 7F, 80, 45, one byte per slot.
